ofdm_frame_assembler: RTL and testbench
=======================================

Name: ofdm_frame_assembler

Overview:
Sits directly downstream of the pilot/data mapper. Consumes its 40-bit beats (8 carriers x 5-bit field: bit0 = pilot flag, bits[4:1] = payload nibble). Emits complete frames to the IFFT-side stream: one BPSK sync symbol built from sync_word, then SYMBOLS_PER_FRAME data symbols passed through. Frames tlast per symbol and flags input framing errors.

Parameters:
SYMBOLS_PER_FRAME, 10, data symbols per frame (sync symbol not counted)
USED_CARRIERS, 800, carriers per symbol; must equal sync_word width
CARRIERS_PER_BEAT, 8, carriers per AXIS beat; USED_CARRIERS % CARRIERS_PER_BEAT == 0
C_AXIS_DATA_TDATA_WIDTH, 40, 5*CARRIERS_PER_BEAT
(localparam BEATS_PER_SYMBOL = USED_CARRIERS/CARRIERS_PER_BEAT = 100)

Ports:
s_axis_data_aclk  in  1  single clock for both streams
s_axis_data_aresetn  in  1  asynchronous, active-low reset
s_axis_data_tvalid  in  1  mapper beat valid
s_axis_data_tready  out  1  ready to mapper
s_axis_data_tdata  in  40  8 carrier fields
s_axis_data_tlast  in  1  mapper end-of-symbol marker
sync_word  in  USED_CARRIERS  sync pattern, bit k = carrier k
m_axis_data_tvalid  out  1  output beat valid
m_axis_data_tready  in  1  downstream ready
m_axis_data_tdata  out  40  output carrier fields
m_axis_data_tlast  out  1  last beat of every symbol (sync and data)
frame_err  out  1  sticky: input tlast misaligned with symbol boundary

Behaviour:
- Reset (async assert, sync-released by caller): state=SYNC, beat_cnt=0, sym_cnt=0, m_tvalid=0, m_tdata=0, m_tlast=0, s_tready=0, frame_err=0.
- Output is a single registered stage: load when !m_tvalid || m_tready ("slot free"). Once m_tvalid=1, tdata/tlast hold until m_tready. No combinational path m_tready->m_tdata.
- States: SYNC -> DATA -> SYNC (NULL inserted when optional feature enabled).
- SYNC entry (beat_cnt==0): latch sync_word into sync_q; changes to sync_word during a sync symbol have no effect until next frame.
- SYNC: s_tready=0. Each free slot loads beat b=beat_cnt: field j = {sync_q[b*8+j] ? 4'h1 : 4'hF, 1'b0} (BPSK +1/-1 as 4-bit two's complement, pilot flag 0). tlast=1 at b=99; then beat_cnt=0, state=DATA.
- DATA: s_tready = slot free (combinational from registered state only). Transfer on s_tvalid&&s_tready: tdata copied unchanged, 1-cycle latency. beat_cnt wraps 99->0 with m_tlast=1; sym_cnt increments; after symbol SYMBOLS_PER_FRAME-1 completes -> sym_cnt=0, state=SYNC.
- Output tlast is generated by count, never from input tlast.
- frame_err set when accepted input beat has s_tlast != (beat_cnt==99); cleared only by reset. Stream continues on count regardless.
- Throughput: 1 beat/cycle sustained with m_tready=1, including SYNC->DATA and DATA->SYNC transitions (no bubble).
- Widths: beat_cnt = $clog2(BEATS_PER_SYMBOL), sym_cnt = $clog2(SYMBOLS_PER_FRAME+1).
- Reset mid-frame: all counters/state to reset values, in-flight output beat dropped; next frame starts with a fresh sync symbol.

Optional Feature:
OFDM_ASM_NULL_SYM_EN: when defined, state NULL follows the last data symbol: 100 all-zero beats (tdata=0, tlast on beat 99), s_tready=0, then SYNC. Frame = 1+SYMBOLS_PER_FRAME+1 symbols. When undefined, DATA goes straight to SYNC and NULL logic is absent.

Decomposition:
- Package ofdm_framer_pkg: state enum (SYNC, DATA, NULL), FIELD_W=5, BPSK_POS=4'h1, BPSK_NEG=4'hF, field-pack function.
- One sub-module: axis_out_reg (1-deep registered output slot with valid/ready); FSM and counters stay in the top.

Test Plan:
- Reset, then m_tready=1, input always valid -> 100 sync beats, then 1000 data beats; tlast on beats 100, 200, ... 1100; beat 1101 is sync again.
- sync_word = alternating 1010..., beat 0 -> m_tdata = {8 fields alternating 5'h1E / 5'h02 per sync bit}; sync_word change at beat 50 -> no effect until next frame.
- Random m_tready (50%) and s_tvalid gaps -> data beats emitted in order, no loss or duplication; tdata stable while tvalid && !tready.
- Input tlast at beat 57 of symbol 3 -> frame_err=1 and stays 1; output tlast still at beat 99.
- Assert aresetn low during data symbol 4 beat 20 -> m_tvalid=0 same cycle; after release, first output is sync beat 0.
- With OFDM_ASM_NULL_SYM_EN: 100 zero beats after symbol 10, s_tready=0 throughout, then sync.

Source files
------------

// File: rtl/ofdm_framer_pkg.sv
// Shared types and helpers for the OFDM frame assembler: FSM states and
// BPSK sync-field packing.
package ofdm_framer_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        DATA = 2'd1,
        NULL = 2'd2
    } asm_state_t;

    localparam int         FIELD_W  = 5;
    localparam logic [3:0] BPSK_POS = 4'h1;
    localparam logic [3:0] BPSK_NEG = 4'hF;

    // One carrier field of the sync symbol: BPSK value in the nibble, pilot flag clear.
    function automatic logic [FIELD_W-1:0] bpsk_field(input logic sync_bit);
        return {(sync_bit ? BPSK_POS : BPSK_NEG), 1'b0};
    endfunction

endpackage

// File: rtl/ofdm_frame_assembler_axis_out_reg.sv
// One-deep registered AXI-Stream output slot; data and last hold while
// valid is high and the sink is not ready.
module axis_out_reg #(
    parameter int DATA_W = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_free
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (o_free) begin
            r_valid <= i_load;
            if (i_load) begin
                r_data <= i_data;
                r_last <= i_last;
            end
        end
    end

endmodule

// File: rtl/ofdm_frame_assembler.sv
// OFDM frame assembler: one BPSK sync symbol, then SYMBOLS_PER_FRAME mapper
// symbols; optional all-zero NULL symbol after the data with OFDM_ASM_NULL_SYM_EN.
module ofdm_frame_assembler
    import ofdm_framer_pkg::*;
#(
    parameter int SYMBOLS_PER_FRAME       = 10,
    parameter int USED_CARRIERS           = 800,
    parameter int CARRIERS_PER_BEAT       = 8,
    parameter int C_AXIS_DATA_TDATA_WIDTH = 40
) (
    input  logic                               s_axis_data_aclk,
    input  logic                               s_axis_data_aresetn,
    input  logic                               s_axis_data_tvalid,
    output logic                               s_axis_data_tready,
    input  logic [C_AXIS_DATA_TDATA_WIDTH-1:0] s_axis_data_tdata,
    input  logic                               s_axis_data_tlast,
    input  logic [USED_CARRIERS-1:0]           sync_word,
    output logic                               m_axis_data_tvalid,
    input  logic                               m_axis_data_tready,
    output logic [C_AXIS_DATA_TDATA_WIDTH-1:0] m_axis_data_tdata,
    output logic                               m_axis_data_tlast,
    output logic                               frame_err
);

    localparam int BEATS_PER_SYMBOL = USED_CARRIERS / CARRIERS_PER_BEAT;
    localparam int BEAT_W           = $clog2(BEATS_PER_SYMBOL);
    localparam int SYM_W            = $clog2(SYMBOLS_PER_FRAME + 1);
    localparam int IDX_W            = $clog2(USED_CARRIERS);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS_PER_SYMBOL - 1);
    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(SYMBOLS_PER_FRAME - 1);

    asm_state_t                           r_state;
    asm_state_t                           w_state_next;
    logic [BEAT_W-1:0]                    r_beat_cnt;
    logic [SYM_W-1:0]                     r_sym_cnt;
    logic [USED_CARRIERS-1:0]             r_sync_q;
    logic                                 r_frame_err;
    logic                                 w_free;
    logic                                 w_load;
    logic                                 w_load_last;
    logic                                 w_s_tready;
    logic                                 w_beat_last;
    logic                                 w_sym_last;
    logic [C_AXIS_DATA_TDATA_WIDTH-1:0]   w_load_data;
    logic [C_AXIS_DATA_TDATA_WIDTH-1:0]   w_sync_beat;
    logic [USED_CARRIERS-1:0]             w_sync_src;
    logic [IDX_W-1:0]                     w_sync_base;
    logic [CARRIERS_PER_BEAT-1:0]         w_sync_bits;

    assign w_beat_last = (r_beat_cnt == BEAT_LAST);
    assign w_sym_last  = (r_sym_cnt == SYM_LAST);

    // Beat 0 reads the live word so the sync symbol starts without a bubble.
    assign w_sync_src  = (r_beat_cnt == '0) ? sync_word : r_sync_q;
    assign w_sync_base = IDX_W'(r_beat_cnt) * IDX_W'(CARRIERS_PER_BEAT);
    assign w_sync_bits = w_sync_src[w_sync_base +: CARRIERS_PER_BEAT];

    generate
        for (genvar gi = 0; gi < CARRIERS_PER_BEAT; gi++) begin : g_sync_field
            assign w_sync_beat[gi*FIELD_W +: FIELD_W] = bpsk_field(w_sync_bits[gi]);
        end
    endgenerate

    always_ff @(posedge s_axis_data_aclk or negedge s_axis_data_aresetn) begin
        if (!s_axis_data_aresetn) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_load && w_beat_last) begin
            case (r_state)
                SYNC: w_state_next = DATA;
`ifdef OFDM_ASM_NULL_SYM_EN
                DATA: w_state_next = w_sym_last ? NULL : DATA;
`else
                DATA: w_state_next = w_sym_last ? SYNC : DATA;
`endif
                default: w_state_next = SYNC;
            endcase
        end
    end

    always_comb begin
        w_s_tready  = 1'b0;
        w_load      = 1'b0;
        w_load_data = '0;
        w_load_last = w_beat_last;
        case (r_state)
            SYNC: begin
                w_load      = w_free;
                w_load_data = w_sync_beat;
            end
            DATA: begin
                w_s_tready  = w_free;
                w_load      = w_free && s_axis_data_tvalid;
                w_load_data = s_axis_data_tdata;
            end
`ifdef OFDM_ASM_NULL_SYM_EN
            NULL: begin
                w_load      = w_free;
                w_load_data = '0;
            end
`endif
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge s_axis_data_aclk or negedge s_axis_data_aresetn) begin
        if (!s_axis_data_aresetn) begin
            r_beat_cnt  <= '0;
            r_sym_cnt   <= '0;
            r_sync_q    <= '0;
            r_frame_err <= 1'b0;
        end else if (w_load) begin
            if (r_state == SYNC && r_beat_cnt == '0) begin
                r_sync_q <= sync_word;
            end
            // Input tlast is only checked; output framing comes from the counters.
            if (r_state == DATA && (s_axis_data_tlast != w_beat_last)) begin
                r_frame_err <= 1'b1;
            end
            if (w_beat_last) begin
                r_beat_cnt <= '0;
                if (r_state == DATA) begin
                    r_sym_cnt <= w_sym_last ? '0 : r_sym_cnt + 1'b1;
                end
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    axis_out_reg #(
        .DATA_W(C_AXIS_DATA_TDATA_WIDTH)
    ) u_out_reg (
        .clk     (s_axis_data_aclk),
        .rst_n   (s_axis_data_aresetn),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_last  (w_load_last),
        .i_ready (m_axis_data_tready),
        .o_valid (m_axis_data_tvalid),
        .o_data  (m_axis_data_tdata),
        .o_last  (m_axis_data_tlast),
        .o_free  (w_free)
    );

    assign s_axis_data_tready = w_s_tready;
    assign frame_err          = r_frame_err;

endmodule

// File: tb/tb_ofdm_frame_assembler.sv
// Directed + randomized bench for ofdm_frame_assembler with an output scoreboard.
module tb_ofdm_frame_assembler;

    localparam int SPF = 10;
    localparam int UC  = 800;
    localparam int CPB = 8;
    localparam int TW  = 40;
    localparam int BPS = 100;
`ifdef OFDM_ASM_NULL_SYM_EN
    localparam int FRAME_SYMS = SPF + 2;
`else
    localparam int FRAME_SYMS = SPF + 1;
`endif
    localparam int FRAME_BEATS = FRAME_SYMS * BPS;
    localparam int DATA_BEATS  = SPF * BPS;
    localparam int INJECT_IDX  = 3 * BPS + 57;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [TW-1:0] s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic [UC-1:0] sync_word = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [TW-1:0] m_tdata;
    logic          m_tlast;
    logic          frame_err;

    ofdm_frame_assembler dut (
        .s_axis_data_aclk    (clk),
        .s_axis_data_aresetn (rst_n),
        .s_axis_data_tvalid  (s_tvalid),
        .s_axis_data_tready  (s_tready),
        .s_axis_data_tdata   (s_tdata),
        .s_axis_data_tlast   (s_tlast),
        .sync_word           (sync_word),
        .m_axis_data_tvalid  (m_tvalid),
        .m_axis_data_tready  (m_tready),
        .m_axis_data_tdata   (m_tdata),
        .m_axis_data_tlast   (m_tlast),
        .frame_err           (frame_err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [TW-1:0] exp_q[$];
    int            out_cnt = 0;
    int            in_cnt = 0;
    int            cyc = 0;
    logic [UC-1:0] frame_sync = '0;
    bit            prev_stall = 0;
    logic [TW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    bit            in_acc = 0;
    bit            inject_en = 0;
    bit            inj_live = 0;
    bit            injected = 0;
    bit            check_alt = 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] sync_beat(input logic [UC-1:0] sw, input int b);
        logic [TW-1:0] r;
        r = '0;
        for (int j = 0; j < CPB; j++) begin
            r[j*5 +: 5] = sw[b*CPB + j] ? 5'h02 : 5'h1E;
        end
        return r;
    endfunction

    task automatic pop_check();
        int pos;
        int sym;
        int b;
        logic [TW-1:0] e;
        pos = out_cnt % FRAME_BEATS;
        sym = pos / BPS;
        b   = pos % BPS;
        e   = '0;
        if (pos == 0) frame_sync = sync_word;
        if (sym == 0) begin
            e = sync_beat(frame_sync, b);
        end else if (sym <= SPF) begin
            chk($sformatf("sb_nonempty@%0d", out_cnt), (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
        end
        if (check_alt && out_cnt == 0) begin
            chk("sync_beat0_alt", m_tdata, 40'h1785E1785E);
            check_alt = 0;
        end
        chk($sformatf("m_tdata@%0d", out_cnt), m_tdata, e);
        chk($sformatf("m_tlast@%0d", out_cnt), m_tlast, (b == BPS - 1));
        out_cnt++;
    endtask

    task automatic cycle();
        int   lpos;
        logic exp_rdy;
        @(negedge clk);
        in_acc = 0;
        if (rst_n) begin
            lpos    = (out_cnt + (m_tvalid ? 1 : 0)) % FRAME_BEATS;
            exp_rdy = (lpos >= BPS && lpos < (SPF + 1) * BPS) ? (!m_tvalid || m_tready) : 1'b0;
            chk($sformatf("s_tready@cyc%0d", cyc), s_tready, exp_rdy);
            if (prev_stall) begin
                chk("hold_valid", m_tvalid, 1);
                chk("hold_data", m_tdata, prev_data);
                chk("hold_last", m_tlast, prev_last);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (m_tvalid && m_tready) pop_check();
            in_acc = s_tvalid && s_tready;
            if (in_acc) begin
                exp_q.push_back(s_tdata);
                in_cnt++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit valid_on);
        if (in_acc && inj_live) injected = 1;
        if (!(s_tvalid && !in_acc)) begin
            s_tvalid = valid_on;
            s_tdata  = TW'({$urandom(), $urandom()});
        end
        s_tlast  = ((in_cnt % BPS) == BPS - 1);
        inj_live = inject_en && !injected && ((in_cnt % DATA_BEATS) == INJECT_IDX);
        if (inj_live) s_tlast = 1'b1;
    endtask

    initial begin
        int guard;
        int cyc_first;
        bit changed;
        bit pre_checked;
        for (int k = 0; k < UC; k++) sync_word[k] = k[0];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_frame_err", frame_err, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_tready = 1'b1;
        drive(1);

        // Full-rate frame plus first beat of the next sync symbol
        guard = 0;
        cyc_first = 0;
        changed = 0;
        while (out_cnt < FRAME_BEATS + 1 && guard < 5000) begin
            cycle();
            guard++;
            if (out_cnt == 1 && cyc_first == 0) cyc_first = cyc;
            if (out_cnt == 50 && !changed) begin
                for (int k = 0; k < UC; k++) sync_word[k] = $urandom_range(0, 1);
                changed = 1;
            end
            drive(1);
        end
        chk("phase1_done", out_cnt, FRAME_BEATS + 1);
        chk("no_bubble_cycles", cyc - cyc_first, FRAME_BEATS);
        chk("frame_err_clean", frame_err, 0);

        // Random backpressure and input gaps, with one misplaced input tlast
        inject_en = 1;
        pre_checked = 0;
        guard = 0;
        while (!injected && guard < 20000) begin
            cycle();
            guard++;
            m_tready = $urandom_range(0, 1);
            drive($urandom_range(0, 1));
            if (inj_live && !pre_checked) begin
                chk("frame_err_pre", frame_err, 0);
                pre_checked = 1;
            end
        end
        chk("inject_reached", injected, 1);
        for (int i = 0; i < 400; i++) begin
            cycle();
            m_tready = $urandom_range(0, 1);
            drive($urandom_range(0, 1));
        end
        chk("frame_err_set", frame_err, 1);
        inject_en = 0;

        // Run to data symbol 4, beat 20, then reset mid-frame
        m_tready = 1'b1;
        guard = 0;
        while ((out_cnt % FRAME_BEATS) != 5 * BPS + 20 && guard < 20000) begin
            cycle();
            guard++;
            drive(1);
        end
        chk("reach_mid_frame", out_cnt % FRAME_BEATS, 5 * BPS + 20);
        chk("frame_err_sticky", frame_err, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_s_tready", s_tready, 0);
        exp_q.delete();
        out_cnt    = 0;
        in_cnt     = 0;
        prev_stall = 0;
        in_acc     = 0;
        s_tvalid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1);
        for (int i = 0; i < 250; i++) begin
            cycle();
            drive(1);
        end
        chk("restart_popped", out_cnt >= 240, 1);
        chk("restart_frame_err", frame_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
